// File: rtl/snake_pkg.sv
// snake_pkg: shared direction encodings, master-state constant, colours and helpers
package snake_pkg;
  typedef enum logic [1:0] {D_UP = 2'd0, D_RIGHT = 2'd1, D_DOWN = 2'd2, D_LEFT = 2'd3} dir_t;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [11:0] SNAKE_DEF = 12'h0F0;
  localparam logic [11:0] HEAD_DEF = 12'hFF0;
  localparam logic [11:0] TARGET_DEF = 12'hF00;
  localparam logic [11:0] BG_DEF = 12'h00F;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction
endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: move-tick prescaler that holds its count while disabled
module snake_tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic enable,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  logic [CW-1:0] cnt;
  assign tick = enable && cnt == LAST;
  // count enabled cycles, wrapping to zero on the tick cycle
  always_ff @(posedge CLK)
    if (RESET) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body shift register, collision/capture logic and pixel colour
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30,
  parameter int X_BITS = 6,
  parameter int Y_BITS = 5,
  parameter int CELL_SHIFT = 4,
  parameter int MAX_LEN = 32,
  parameter int INIT_LEN = 4,
  parameter int TICK_DIV = 12_500_000,
  parameter int WRAP = 0,
  parameter logic [11:0] SNAKE_COL = SNAKE_DEF,
  parameter logic [11:0] HEAD_COL = HEAD_DEF,
  parameter logic [11:0] TARGET_COL = TARGET_DEF,
  parameter logic [11:0] BG_COL = BG_DEF
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [9:0]                       ADDR_H,
  input  logic [8:0]                       ADDR_V,
  input  logic [1:0]                       M_STATE,
  input  logic [1:0]                       DIR,
  input  logic [X_BITS-1:0]                TARGET_H,
  input  logic [Y_BITS-1:0]                TARGET_V,
  output logic                             REACHED,
  output logic                             HIT,
  output logic [11:0]                      COLOUR,
  output logic [$clog2(MAX_LEN+1)-1:0]     LENGTH
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [X_BITS-1:0] XMAX = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] YMAX = Y_BITS'(GRID_H - 1);
  logic [X_BITS-1:0] bx [MAX_LEN];
  logic [Y_BITS-1:0] by [MAX_LEN];
  dir_t head, nd;
  logic tick, at_edge, capture, grow, self_hit, hit_now;
  logic [X_BITS-1:0] nx;
  logic [Y_BITS-1:0] ny;
  logic [9:0] cx;
  logic [8:0] cy;
  logic in_grid, head_px, body_px, target_px;
  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK(CLK),
    .RESET(RESET),
    .enable(M_STATE == PLAY && !HIT),
    .tick(tick)
  );
  // next head position, capture and collision decisions for the coming tick
  always_comb begin
    nd = dir_t'(DIR) == opposite(head) ? head : dir_t'(DIR);
    at_edge = (nd == D_RIGHT && bx[0] == XMAX) || (nd == D_LEFT && bx[0] == '0) ||
              (nd == D_DOWN && by[0] == YMAX) || (nd == D_UP && by[0] == '0);
    nx = nd == D_RIGHT ? (bx[0] == XMAX ? '0 : bx[0] + 1'b1) :
         nd == D_LEFT ? (bx[0] == '0 ? XMAX : bx[0] - 1'b1) : bx[0];
    ny = nd == D_DOWN ? (by[0] == YMAX ? '0 : by[0] + 1'b1) :
         nd == D_UP ? (by[0] == '0 ? YMAX : by[0] - 1'b1) : by[0];
    capture = nx == TARGET_H && ny == TARGET_V;
    grow = capture && LENGTH < LW'(MAX_LEN);
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((i + 1 < int'(LENGTH) || (grow && i < int'(LENGTH))) && bx[i] == nx && by[i] == ny) self_hit = 1'b1;
    hit_now = self_hit || (WRAP == 0 && at_edge);
  end
  // body shift, heading, length and flags; the tick never fires once HIT is set
  always_ff @(posedge CLK)
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        bx[i] <= X_BITS'(GRID_W / 2 - i);
        by[i] <= Y_BITS'(GRID_H / 2);
      end
      head <= D_RIGHT;
      LENGTH <= LW'(INIT_LEN);
      HIT <= 1'b0;
      REACHED <= 1'b0;
    end else begin
      REACHED <= tick && !hit_now && capture;
      if (tick && hit_now) HIT <= 1'b1;
      if (tick && !hit_now) begin
        head <= nd;
        bx[0] <= nx;
        by[0] <= ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          bx[i] <= bx[i-1];
          by[i] <= by[i-1];
        end
        if (grow) LENGTH <= LENGTH + 1'b1;
      end
    end
  // classify the scanned cell against head, live segments and target
  always_comb begin
    cx = ADDR_H >> CELL_SHIFT;
    cy = ADDR_V >> CELL_SHIFT;
    in_grid = cx < 10'(GRID_W) && cy < 9'(GRID_H);
    head_px = cx == 10'(bx[0]) && cy == 9'(by[0]);
    target_px = cx == 10'(TARGET_H) && cy == 9'(TARGET_V);
    body_px = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (i < int'(LENGTH) && cx == 10'(bx[i]) && cy == 9'(by[i])) body_px = 1'b1;
  end
  // registered colour stage
  always_ff @(posedge CLK)
    COLOUR <= RESET || !in_grid ? BG_COL : head_px ? HEAD_COL : body_px ? SNAKE_COL : target_px ? TARGET_COL : BG_COL;
endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised successor to the fixed-size snake controller. Holds the snake body as a shift register of cell coordinates and advances it one cell per move tick. Detects target capture (grows the body), wall and self collisions, with an optional wrap-around mode. Drives the pixel colour for the VGA address currently being scanned. Sits between the master state machine (`M_STATE`), the direction decoder (`DIR`), the target generator (`TARGET_*`) and the VGA colour mux.

## Interface
Parameters:
- `GRID_W`, 40: grid width in cells.
- `GRID_H`, 30: grid height in cells.
- `X_BITS`, 6: cell x-coordinate width. Must satisfy 2^`X_BITS` ≥ `GRID_W`.
- `Y_BITS`, 5: cell y-coordinate width. Must satisfy 2^`Y_BITS` ≥ `GRID_H`.
- `CELL_SHIFT`, 4: log2 of pixels per cell side.
- `MAX_LEN`, 32: body capacity in segments.
- `INIT_LEN`, 4: length after reset. Range 2..`MAX_LEN`.
- `TICK_DIV`, 12_500_000: clock cycles per move tick.
- `WRAP`, 0: 0 = a wall is fatal; 1 = the head wraps to the opposite edge.
- `SNAKE_COL` 12'h0F0, `HEAD_COL` 12'hFF0, `TARGET_COL` 12'hF00, `BG_COL` 12'h00F: colour values.

Ports:
- `CLK` in 1: the single clock.
- `RESET` in 1: synchronous, active-high reset.
- `ADDR_H` in 10: VGA pixel x.
- `ADDR_V` in 9: VGA pixel y.
- `M_STATE` in 2: master state. 1 = PLAY; any other value freezes the engine.
- `DIR` in 2: requested heading. 0 up, 1 right, 2 down, 3 left.
- `TARGET_H` in `X_BITS`, `TARGET_V` in `Y_BITS`: target cell.
- `REACHED` out 1: one-cycle pulse on target capture.
- `HIT` out 1: sticky collision flag.
- `COLOUR` out 12: pixel colour.
- `LENGTH` out clog2(`MAX_LEN`+1): current body length.

## Operation
Reset values:
- Head (segment 0) at (`GRID_W`/2, `GRID_H`/2).
- Segment i at (head_x − i, head_y).
- `LENGTH`=`INIT_LEN`, heading right.
- `HIT`=0, `REACHED`=0, `COLOUR`=`BG_COL`, tick counter 0.

States:
- RUN: tick counter advances while `M_STATE`==1.
- FROZEN: entered when `M_STATE`≠1; the counter holds its value. Leaving FROZEN resumes from the held count.
- DEAD: entered when `HIT` is set; the body and counter hold. Only `RESET` leaves DEAD.

Move tick (counter reaches `TICK_DIV`−1, then the counter wraps to 0):
- `DIR` is sampled at the tick. If it is the exact reverse of the current heading, it is ignored and the heading is kept.
- next_head = head ± 1 along the heading.
- With `WRAP`=0, leaving 0..`GRID_W`−1 or 0..`GRID_H`−1 is a wall hit.
- With `WRAP`=1, x wraps `GRID_W`−1↔0 and y wraps `GRID_H`−1↔0.
- grow = (next_head == target) and `LENGTH` < `MAX_LEN`.
- Self hit: next_head equals any segment with index < `LENGTH`−1. When grow is set, the range extends to index < `LENGTH`, because the tail does not vacate.
- On any hit: set `HIT`; no shift; `REACHED` stays 0. A hit takes priority over capture on the same tick.
- Otherwise, shift segments i ← i−1 and load next_head into segment 0.
- On capture (next_head == target): pulse `REACHED` for one cycle. `LENGTH` increments, saturating at `MAX_LEN`. At saturation the pulse still fires but the body does not grow.

Colour (one registered stage):
- The cell is (`ADDR_H`>>`CELL_SHIFT`, `ADDR_V`>>`CELL_SHIFT`).
- Priority: segment 0 → `HEAD_COL`; any segment < `LENGTH` → `SNAKE_COL`; target → `TARGET_COL`; else `BG_COL`.
- Pixels outside the grid → `BG_COL`.
- Segments with index ≥ `LENGTH` never render and never collide.

## Timing
- `COLOUR` is valid one cycle after `ADDR_H`/`ADDR_V`.
- Body, `LENGTH`, `HIT` and `REACHED` update on the clock edge at the end of the tick cycle. All are visible in the following cycle.
- `REACHED` is high for exactly one cycle per capture.
- `RESET` during any state restores all reset values on the next edge.

## Structure
- Shared `snake_pkg`: direction encodings, the `M_STATE` PLAY constant, the opposite-direction function, and default colour constants.
- Sub-module `snake_tick_gen`: the `TICK_DIV` prescaler. Inputs `CLK`, `RESET`, enable (= `M_STATE`==1 && !`HIT`); output a one-cycle tick.
- The body is a `MAX_LEN`-entry array. Collision and render compares are `MAX_LEN` parallel comparators gated by `LENGTH`.

## Test plan
All scenarios use `TICK_DIV`=4, `CELL_SHIFT`=4.
- Reset, `M_STATE`=1, `DIR`=1, target (0,0) → after 4 cycles the head moves (20,15)→(21,15); `ADDR_H`=336, `ADDR_V`=240 gives `HEAD_COL` one cycle later.
- Target (22,15), `DIR`=1 → `REACHED` pulses once on the 2nd tick; `LENGTH` 4→5; tail cell (18,15) is still `SNAKE_COL`.
- Heading right, `DIR`=3 at a tick → head continues to x+1; `HIT`=0.
- `WRAP`=0, drive right to x=39, next tick → `HIT`=1 and the head stays at 39. `WRAP`=1, same stimulus → head at x=0, `HIT`=0.
- `INIT_LEN`=6, `DIR` down, left, up on successive ticks → `HIT`=1 on the 3rd tick. With `INIT_LEN`=4, the same sequence gives no hit (tail vacates).
- `M_STATE`=0 for 20 cycles → no movement; `RESET` mid-game → `LENGTH`=`INIT_LEN`, head (20,15), `HIT`=0.
